isa_core_mc: RTL and testbench

- Parametrised multicycle successor to the fixed 14-bit three-operand machine: FSM control, PC, IR, operand registers, ALU, result register.
- Memory is external behind a req/ack handshake, so wait-state RAMs are supported.
- Adds over the previous core: reset, start/halt control, SUB/branch/HALT opcodes, carry flag, generic operand width.
- Single shared memory: program in the lower half, data in the upper half (address MSB=1, the fixed "offset" bit).

---
 rtl/isa_core_mc_if.sv | 51 +++++
 rtl/isa_core_mc.sv | 251 +++++++++++++++++++++++++
 tb/tb_isa_core_mc.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/isa_core_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : isa_core_mc_if
// Description : Memory bus between the multicycle core and a shared
//               program/data RAM. Request/acknowledge handshake with
//               support for any number of wait states.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals
//   mem_req   : access request, held for the whole access
//   mem_we    : 1 = write, 0 = read (valid while mem_req = 1)
//   mem_addr  : word address, MSB selects the data half
//   mem_wdata : write data
//   mem_rdata : read data, taken on the edge where mem_ack = 1
//   mem_ack   : access complete; may already be high in the first req cycle
// Modports
//   master    : core side
//   slave     : memory side
// ============================================================================
interface isa_core_mc_if #(
    parameter int FW = 4
) ();
    localparam int IW = 2 + 3 * FW;
    localparam int AW = FW + 1;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_wdata;
    logic [IW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/isa_core_mc.sv
`default_nettype none
// ============================================================================
// Module      : isa_core_mc
// Description : Parametrised multicycle three-operand core. One shared
//               memory holds the program (address MSB = 0) and the data
//               (address MSB = 1). Instruction word = {op, a, b, c}.
//                 00 ADD  : D[a] <= D[b] + D[c]
//                 01 SUB  : D[a] <= D[b] - D[c]
//                 10 BZ   : if D[b] == 0 then pc <= a
//                 11 HALT
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   FW             : operand field width, also the PC width
// Ports
//   clk            : system clock, rising edge
//   rst_n          : asynchronous active-low reset
//   start_i        : one-cycle pulse, starts execution at PC = 0 from
//                    IDLE or HALT; ignored while busy
//   mem            : memory bus (master side)
//   resultado_o    : last value written to data memory
//   result_valid_o : one-cycle pulse in the cycle after each data write
//   carry_o        : carry (ADD) or borrow (SUB) of the last ALU op
//   pc_o           : current program counter
//   busy_o         : high in every state except IDLE and HALT
//   halted_o       : high in HALT
// ============================================================================
module isa_core_mc #(
    parameter int FW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    isa_core_mc_if.master     mem,
    output logic [2+3*FW-1:0] resultado_o,
    output logic              result_valid_o,
    output logic              carry_o,
    output logic [FW-1:0]     pc_o,
    output logic              busy_o,
    output logic              halted_o
);

    localparam int IW = 2 + 3 * FW;
    localparam int AW = FW + 1;

    localparam logic [1:0]    OP_ADD  = 2'b00;
    localparam logic [1:0]    OP_SUB  = 2'b01;
    localparam logic [1:0]    OP_BZ   = 2'b10;
    localparam logic [1:0]    OP_HALT = 2'b11;

    localparam logic [FW-1:0] PC_ONE  = {{(FW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_RD_B   = 3'd3,
        S_RD_C   = 3'd4,
        S_EXEC   = 3'd5,
        S_WR     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    // ------------------------------------------------------------------------
    // Architectural and control registers
    // ------------------------------------------------------------------------
    state_t        state_q;
    logic [FW-1:0] pc_q;
    logic [IW-1:0] ir_q;
    logic [IW-1:0] opb_q;
    logic [IW-1:0] opc_q;
    logic [IW-1:0] result_q;      // ALU result, also drives mem_wdata in WR
    logic [IW-1:0] resultado_q;
    logic          carry_q;
    logic          valid_q;

    // Bus outputs are registered so they are glitch-free and stay put
    // until the acknowledging edge.
    logic          req_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic          busy_q;
    logic          halted_q;

    // ------------------------------------------------------------------------
    // Instruction fields and datapath
    // ------------------------------------------------------------------------
    logic [1:0]    w_op;
    logic [FW-1:0] w_a;
    logic [FW-1:0] w_b;
    logic [FW-1:0] w_c;
    logic [IW:0]   w_alu;
    logic [FW-1:0] w_pc_inc;
    logic [FW-1:0] w_bz_pc;

    assign w_op = ir_q[IW-1:IW-2];
    assign w_a  = ir_q[3*FW-1:2*FW];
    assign w_b  = ir_q[2*FW-1:FW];
    assign w_c  = ir_q[FW-1:0];

    // One extra bit: carry-out for ADD; for SUB the top bit of the
    // zero-extended difference is set exactly when opb < opc (borrow).
    always_comb begin
        w_alu = '0;
        if (w_op == OP_SUB) begin
            w_alu = {1'b0, opb_q} - {1'b0, opc_q};
        end else begin
            w_alu = {1'b0, opb_q} + {1'b0, opc_q};
        end
    end

    assign w_pc_inc = pc_q + PC_ONE;

    // pc already points past the branch when EXEC runs, so a taken
    // branch simply replaces it.
    assign w_bz_pc  = (opb_q == '0) ? w_a : pc_q;

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            opb_q       <= '0;
            opc_q       <= '0;
            result_q    <= '0;
            resultado_q <= '0;
            carry_q     <= 1'b0;
            valid_q     <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            case (state_q)
                S_IDLE, S_HALT: begin
                    if (start_i) begin
                        pc_q     <= '0;
                        req_q    <= 1'b1;
                        we_q     <= 1'b0;
                        addr_q   <= '0;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                        state_q  <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (mem.mem_ack) begin
                        ir_q    <= mem.mem_rdata;
                        pc_q    <= w_pc_inc;
                        req_q   <= 1'b0;
                        state_q <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    if (w_op == OP_HALT) begin
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= {1'b1, w_b};
                        state_q <= S_RD_B;
                    end
                end

                S_RD_B: begin
                    if (mem.mem_ack) begin
                        opb_q <= mem.mem_rdata;
                        if (w_op == OP_BZ) begin
                            req_q   <= 1'b0;
                            state_q <= S_EXEC;
                        end else begin
                            // Second operand read follows back to back.
                            addr_q  <= {1'b1, w_c};
                            state_q <= S_RD_C;
                        end
                    end
                end

                S_RD_C: begin
                    if (mem.mem_ack) begin
                        opc_q   <= mem.mem_rdata;
                        req_q   <= 1'b0;
                        state_q <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (w_op == OP_BZ) begin
                        pc_q    <= w_bz_pc;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= {1'b0, w_bz_pc};
                        state_q <= S_FETCH;
                    end else begin
                        result_q <= w_alu[IW-1:0];
                        carry_q  <= w_alu[IW];
                        req_q    <= 1'b1;
                        we_q     <= 1'b1;
                        addr_q   <= {1'b1, w_a};
                        state_q  <= S_WR;
                    end
                end

                S_WR: begin
                    if (mem.mem_ack) begin
                        resultado_q <= result_q;
                        valid_q     <= 1'b1;
                        we_q        <= 1'b0;
                        addr_q      <= {1'b0, pc_q};
                        state_q     <= S_FETCH;
                    end
                end

                default: begin
                    req_q    <= 1'b0;
                    we_q     <= 1'b0;
                    busy_q   <= 1'b0;
                    halted_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mem.mem_req    = req_q;
    assign mem.mem_we     = we_q;
    assign mem.mem_addr   = addr_q;
    assign mem.mem_wdata  = result_q;

    assign resultado_o    = resultado_q;
    assign result_valid_o = valid_q;
    assign carry_o        = carry_q;
    assign pc_o           = pc_q;
    assign busy_o         = busy_q;
    assign halted_o       = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_isa_core_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_isa_core_mc
// Description : Self-checking bench for isa_core_mc. Behavioural RAM with
//               programmable wait states, write scoreboard, fetch log and
//               handshake stability monitor; directed program sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_isa_core_mc;

    localparam int FW = 4;
    localparam int IW = 2 + 3 * FW;
    localparam int AW = FW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [IW-1:0] resultado;
    logic          result_valid;
    logic          carry;
    logic [FW-1:0] pc;
    logic          busy;
    logic          halted;

    always #5 clk = ~clk;

    isa_core_mc_if #(.FW(FW)) bus ();

    isa_core_mc #(.FW(FW)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .mem            (bus),
        .resultado_o    (resultado),
        .result_valid_o (result_valid),
        .carry_o        (carry),
        .pc_o           (pc),
        .busy_o         (busy),
        .halted_o       (halted)
    );

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural memory with wait states
    // ------------------------------------------------------------------------
    logic [IW-1:0] mem [0:(1<<AW)-1];
    int            wait_n  = 0;
    logic          hold_wr = 1'b0;
    int            wcnt;

    assign bus.mem_ack   = bus.mem_req && !(hold_wr && bus.mem_we) && (wcnt == wait_n);
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         wcnt <= 0;
        else if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
        else                                wcnt <= 0;
    end

    // ------------------------------------------------------------------------
    // Monitor: scoreboard, fetch log, handshake stability, timing marks
    // ------------------------------------------------------------------------
    typedef struct { int addr; int data; } wr_t;
    wr_t           sb[$];
    int            fetch_q[$];
    int            fetch_cyc[$];
    int            cyc = 0;
    int            start_cyc = 0;
    int            wr_cyc = -10;
    int            vcount = 0;
    logic [IW-1:0] last_wdata = '0;
    logic          pend = 1'b0;
    int            len = 0;
    logic          p_we;
    logic [AW-1:0] p_addr;
    logic [IW-1:0] p_wdata;

    always @(posedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (start_i && !busy) start_cyc = cyc;
            if (pend) begin
                chk("req_held", bus.mem_req, 1);
                chk("addr_stable", bus.mem_addr, p_addr);
                chk("we_stable", bus.mem_we, p_we);
                chk("wdata_stable", bus.mem_wdata, p_wdata);
            end
            pend = 1'b0;
            if (bus.mem_req) begin
                if (bus.mem_ack) begin
                    chk("req_len", len + 1, wait_n + 1);
                    len = 0;
                    if (bus.mem_we) begin
                        mem[bus.mem_addr] = bus.mem_wdata;
                        wr_cyc     = cyc;
                        last_wdata = bus.mem_wdata;
                        chk("sb_has_entry", (sb.size() > 0), 1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            chk("wr_addr", bus.mem_addr, e.addr);
                            chk("wr_data", bus.mem_wdata, e.data);
                        end
                    end else if (!bus.mem_addr[AW-1]) begin
                        fetch_q.push_back(int'(bus.mem_addr));
                        fetch_cyc.push_back(cyc);
                    end
                end else begin
                    pend    = 1'b1;
                    len++;
                    p_we    = bus.mem_we;
                    p_addr  = bus.mem_addr;
                    p_wdata = bus.mem_wdata;
                end
            end else begin
                len = 0;
            end
        end else begin
            pend = 1'b0;
            len  = 0;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            vcount++;
            chk("rv_timing", cyc, wr_cyc + 1);
            chk("rv_data", resultado, last_wdata);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic clear_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input string tag);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_halt_reached"}, halted, 1);
    endtask

    task automatic new_run();
        fetch_q.delete();
        fetch_cyc.delete();
        vcount = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "[TB] timeout");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int n;
        clear_mem();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 0);
        chk("rst_resultado", resultado, 0);
        chk("rst_carry", carry, 0);
        chk("rst_rv", result_valid, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start_busy", busy, 0);
        chk("idle_no_start_req", bus.mem_req, 0);

        // ADD zero-wait
        mem[0] = 14'h0201; mem[1] = 14'h3000; mem[16] = 14'd5; mem[17] = 14'd7;
        new_run();
        sb.push_back('{18, 12});
        pulse_start();
        wait_halt(100, "add");
        chk("add_latency", wr_cyc - start_cyc, 6);
        chk("add_resultado", resultado, 12);
        chk("add_carry", carry, 0);
        chk("add_pc", pc, 2);
        chk("add_mem18", mem[18], 12);
        chk("add_rv_count", vcount, 1);
        chk("add_fetch_n", fetch_q.size(), 2);
        chk("add_fetch1", fetch_q[1], 1);

        // Self-overlapping operands with overflow: D[3] <= D[3] + D[3]
        mem[0] = 14'h0333; mem[19] = 14'h2001;
        new_run();
        sb.push_back('{19, 14'h0002});
        pulse_start();
        wait_halt(100, "ovl");
        chk("ovl_resultado", resultado, 14'h0002);
        chk("ovl_carry", carry, 1);
        chk("ovl_mem19", mem[19], 14'h0002);

        // SUB with borrow
        mem[0] = 14'h1201; mem[16] = 14'd3; mem[17] = 14'd5;
        new_run();
        sb.push_back('{18, 14'h3FFE});
        pulse_start();
        wait_halt(100, "sub");
        chk("sub_resultado", resultado, 14'h3FFE);
        chk("sub_carry", carry, 1);
        chk("sub_mem18", mem[18], 14'h3FFE);

        // HALT latency and restart from HALT
        mem[0] = 14'h3000;
        new_run();
        pulse_start();
        chk("restart_busy", busy, 1);
        chk("restart_req", bus.mem_req, 1);
        chk("restart_addr", bus.mem_addr, 0);
        chk("restart_halted", halted, 0);
        @(negedge clk);
        chk("halt_lat_c1", halted, 0);
        @(negedge clk);
        chk("halt_lat_c2", halted, 1);
        chk("halt_pc", pc, 1);
        chk("halt_carry_kept", carry, 1);

        // BZ taken
        mem[0] = 14'h2530; mem[19] = 14'd0; mem[5] = 14'h3000;
        new_run();
        pulse_start();
        wait_halt(100, "bzt");
        chk("bzt_fetch_n", fetch_q.size(), 2);
        chk("bzt_fetch1", fetch_q[1], 5);
        chk("bzt_latency", fetch_cyc[1] - start_cyc, 5);
        chk("bzt_carry", carry, 1);
        chk("bzt_pc", pc, 6);

        // BZ not taken
        mem[19] = 14'd1; mem[1] = 14'h3000;
        new_run();
        pulse_start();
        wait_halt(100, "bzn");
        chk("bzn_fetch_n", fetch_q.size(), 2);
        chk("bzn_fetch1", fetch_q[1], 1);
        chk("bzn_carry", carry, 1);
        chk("bzn_pc", pc, 2);

        // Wait states (3 per access) plus a start pulse while busy
        wait_n = 3;
        mem[0] = 14'h0201; mem[1] = 14'h3000; mem[16] = 14'd5; mem[17] = 14'd7;
        new_run();
        sb.push_back('{18, 12});
        pulse_start();
        repeat (4) @(negedge clk);
        pulse_start();
        wait_halt(200, "ws");
        chk("ws_latency", wr_cyc - start_cyc, 18);
        chk("ws_resultado", resultado, 12);
        chk("ws_carry", carry, 0);
        chk("ws_fetch_n", fetch_q.size(), 2);
        chk("ws_pc", pc, 2);
        chk("ws_rv_count", vcount, 1);
        wait_n = 0;

        // PC wrap: BZ to 15, ADD at 15, then fetch wraps to 0 (HALT)
        clear_mem();
        mem[0] = 14'h2F30; mem[15] = 14'h0201; mem[16] = 14'd9; mem[17] = 14'd4;
        new_run();
        sb.push_back('{18, 13});
        pulse_start();
        n = 0;
        while (fetch_q.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_first_fetch", (fetch_q.size() > 0), 1);
        mem[0] = 14'h3000;
        wait_halt(100, "wrap");
        chk("wrap_fetch_n", fetch_q.size(), 3);
        chk("wrap_fetch1", fetch_q[1], 15);
        chk("wrap_fetch2", fetch_q[2], 0);
        chk("wrap_pc", pc, 1);
        chk("wrap_resultado", resultado, 13);

        // Restart after HALT with pc != 0
        new_run();
        pulse_start();
        chk("rs2_busy", busy, 1);
        chk("rs2_addr", bus.mem_addr, 0);
        chk("rs2_we", bus.mem_we, 0);
        wait_halt(50, "rs2");
        chk("rs2_fetch0", fetch_q[0], 0);

        // Reset in the middle of a write with ack withheld
        mem[0] = 14'h0201; mem[1] = 14'h3000; mem[16] = 14'd5; mem[17] = 14'd7;
        hold_wr = 1'b1;
        new_run();
        sb.push_back('{18, 12});
        pulse_start();
        n = 0;
        while (!(bus.mem_req && bus.mem_we) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rwr_in_write", (bus.mem_req && bus.mem_we), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rwr_req", bus.mem_req, 0);
        chk("rwr_pc", pc, 0);
        chk("rwr_resultado", resultado, 0);
        chk("rwr_busy", busy, 0);
        chk("rwr_carry", carry, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        chk("rwr_no_write", mem[18], 13);
        rst_n   = 1'b1;
        hold_wr = 1'b0;
        new_run();
        sb.push_back('{18, 12});
        pulse_start();
        wait_halt(100, "rwr");
        chk("rwr_fetch0", fetch_q[0], 0);
        chk("rwr_resultado2", resultado, 12);

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
